uart_cfg_core: RTL and testbench
================================

Name: uart_cfg_core

Overview:
- Parametrised successor UART core: baud tick generator, oversampling receiver, transmitter and on-chip RX/TX FIFOs in one block.
- Compile-time data width and FIFO depths.
- Run-time parity (none/even/odd) and 1 or 2 stop bits.
- Per-byte parity/framing error tags and a sticky RX overrun flag.
- Sits between the CPU/bus-side byte interface and the board rx/tx pins.

Parameters:
- DBIT, 8, data bits per frame (5..9).
- SB_TICK, 16, oversampling ticks per bit (even, ≥4).
- RX_AW, 4, RX FIFO address width (depth 2**RX_AW).
- TX_AW, 4, TX FIFO address width (depth 2**TX_AW).
- BITS, 11, baud divisor width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- FINAL_VALUE  in  BITS  baud divisor: tick every FINAL_VALUE+1 clocks.
- parity_en  in  1  1 = parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  1 = two stop bits.
- rx  in  1  serial input; idle high.
- rd_uart  in  1  pop RX FIFO head.
- r_data  out  DBIT  RX FIFO head data (first-word fall-through).
- r_par_err  out  1  parity error tag of head byte.
- r_frm_err  out  1  framing error tag of head byte.
- rx_empty  out  1  RX FIFO empty.
- rx_overrun  out  1  sticky: a received byte was dropped.
- clr_overrun  in  1  clears rx_overrun.
- wr_uart  in  1  push w_data into TX FIFO.
- w_data  in  DBIT  byte to transmit.
- tx_full  out  1  TX FIFO full.
- tx  out  1  serial output.
- tx_busy  out  1  transmitter not idle or TX FIFO non-empty.

Behaviour:
Reset values (async assert, all state cleared):
- tx=1, tx_busy=0, rx_empty=1, tx_full=0, rx_overrun=0.
- r_data/r_par_err/r_frm_err=0; FIFO pointers and counters 0; both FSMs idle.

Baud tick:
- Counter 0..FINAL_VALUE, wraps to 0.
- One-cycle tick asserted in the cycle the counter equals FINAL_VALUE.
- FINAL_VALUE changed mid-count: takes effect at the next compare; if the counter is already above the new value it runs to all-ones and wraps (no lockup).

Receiver FSM, IDLE→START→DATA→PARITY→STOP→IDLE; all counting on ticks only:
- IDLE: rx sampled low on a tick → START, s=0.
- START: at s=SB_TICK/2-1, rx low → DATA; rx high → IDLE (glitch rejected, nothing pushed).
- DATA: sample every SB_TICK ticks, LSB first; DBIT bits.
- PARITY (only if parity_en): sample one bit. par_err = received parity ≠ expected (XOR of data, inverted when parity_odd). parity_en=0 → par_err=0.
- STOP: sample after SB_TICK ticks; frm_err = sampled bit is 0. With two_stop, wait a further SB_TICK ticks; the second bit is not checked.
- At STOP exit, one-cycle rx_done pushes {frm_err, par_err, data} into the RX FIFO.
- Mode inputs are sampled at START entry and held for the frame.

RX FIFO:
- Width DBIT+2, depth 2**RX_AW, FWFT; head visible while !rx_empty.
- rd_uart while empty: ignored.
- Push while full: byte dropped, rx_overrun set in the next cycle.
- Simultaneous push and pop while full: both accepted, no overrun.
- clr_overrun coincident with a new overrun: set wins.

Transmitter FSM, IDLE→START→DATA→PARITY→STOP→IDLE:
- IDLE with TX FIFO non-empty: pop one byte (same cycle), latch data and mode inputs, drive tx=0.
- Each bit held SB_TICK ticks; data LSB first.
- Parity bit only if parity_en.
- Stop bits: 1 or 2 per latched two_stop.
- Back-to-back bytes: the next START begins on the cycle after STOP completes, with no extra idle bit.
- tx is registered (glitch-free).

TX FIFO:
- Depth 2**TX_AW.
- wr_uart while full: ignored, contents unchanged.
- Simultaneous push and pop while full: both accepted.

Other rules:
- tx_busy = (TX FSM ≠ IDLE) | !tx_empty.
- Reset mid-frame: tx returns to 1 immediately; partial RX frame discarded; FIFOs emptied.

Test Plan:
- FINAL_VALUE=3, SB_TICK=16, 8N1: rx frame 0xA5 → rx_empty falls; r_data=0xA5, r_par_err=0, r_frm_err=0; rd_uart → rx_empty=1.
- parity_en=1, parity_odd=0: send 0x07 with parity bit 0 (wrong) → r_par_err=1. Resend with parity bit 1 → r_par_err=0.
- Rx frame 0x3C with stop bit driven 0 → r_frm_err=1, byte still stored. A 2-tick low glitch on idle rx → nothing pushed.
- RX_AW=2: send 5 bytes 0x01..0x05 without reads → FIFO holds 0x01..0x04, rx_overrun=1. clr_overrun → rx_overrun=0.
- TX loopback (tx→rx), 8E2: write 0x55, 0xFF, 0x00 → same 3 bytes received in order with no error tags. Frame length 12 bits; tx_busy drops after the last stop bit.
- Assert rst mid TX DATA bit and mid RX DATA bit → tx=1 and FIFOs empty next cycle; next full frame received correctly.

Source files
------------

// File: rtl/uart_cfg_core.sv
// Configurable UART core: baud tick generator, oversampling receiver, transmitter and RX/TX FIFOs.
// Parity and stop-bit mode are latched per frame; each RX byte carries its own error tags.

module uart_cfg_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         full_o
);
   localparam int DEPTH = 2**AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = pop_i & ~empty_o;
   // A full FIFO still takes a push when a pop frees a slot in the same cycle
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (!do_push && do_pop) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end
endmodule

module uart_cfg_core #(
   parameter int DBIT    = 8,
   parameter int SB_TICK = 16,
   parameter int RX_AW   = 4,
   parameter int TX_AW   = 4,
   parameter int BITS    = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [BITS-1:0] FINAL_VALUE,
   input  logic            parity_en,
   input  logic            parity_odd,
   input  logic            two_stop,
   input  logic            rx,
   input  logic            rd_uart,
   output logic [DBIT-1:0] r_data,
   output logic            r_par_err,
   output logic            r_frm_err,
   output logic            rx_empty,
   output logic            rx_overrun,
   input  logic            clr_overrun,
   input  logic            wr_uart,
   input  logic [DBIT-1:0] w_data,
   output logic            tx_full,
   output logic            tx,
   output logic            tx_busy
);
   localparam int SW = $clog2(SB_TICK);
   localparam int NW = $clog2(DBIT);
   localparam logic [SW-1:0] S_LAST = SW'(SB_TICK - 1);
   localparam logic [SW-1:0] S_MID  = SW'(SB_TICK / 2 - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // Baud tick; a counter above a newly lowered FINAL_VALUE rolls over through all-ones
   logic [BITS-1:0] baud_cnt_q;
   logic            tick;

   assign tick = (baud_cnt_q == FINAL_VALUE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) baud_cnt_q <= '0;
      else     baud_cnt_q <= tick ? '0 : baud_cnt_q + BITS'(1);
   end

   logic [1:0] rx_sync_q;
   logic       rx_s;

   assign rx_s = rx_sync_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_sync_q <= 2'b11;
      else     rx_sync_q <= {rx_sync_q[0], rx};
   end

   state_t          rx_state_q;
   logic [SW-1:0]   rx_s_q;
   logic [NW-1:0]   rx_n_q;
   logic [DBIT-1:0] rx_b_q;
   logic            rx_par_en_q, rx_par_odd_q, rx_two_q, rx_stop2_q;
   logic            rx_par_err_q, rx_frm_err_q, rx_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state_q   <= ST_IDLE;
         rx_s_q       <= '0;
         rx_n_q       <= '0;
         rx_b_q       <= '0;
         rx_par_en_q  <= 1'b0;
         rx_par_odd_q <= 1'b0;
         rx_two_q     <= 1'b0;
         rx_stop2_q   <= 1'b0;
         rx_par_err_q <= 1'b0;
         rx_frm_err_q <= 1'b0;
         rx_done_q    <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         case (rx_state_q)
            ST_IDLE: begin
               if (tick && !rx_s) begin
                  rx_state_q   <= ST_START;
                  rx_s_q       <= '0;
                  rx_par_en_q  <= parity_en;
                  rx_par_odd_q <= parity_odd;
                  rx_two_q     <= two_stop;
                  rx_par_err_q <= 1'b0;
               end
            end
            ST_START: begin
               if (tick) begin
                  if (rx_s_q == S_MID) begin
                     rx_s_q     <= '0;
                     rx_n_q     <= '0;
                     rx_state_q <= rx_s ? ST_IDLE : ST_DATA;
                  end else begin
                     rx_s_q <= rx_s_q + SW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (rx_s_q == S_LAST) begin
                     rx_s_q <= '0;
                     rx_b_q <= {rx_s, rx_b_q[DBIT-1:1]};
                     if (rx_n_q == N_LAST) begin
                        rx_stop2_q <= 1'b0;
                        rx_state_q <= rx_par_en_q ? ST_PARITY : ST_STOP;
                     end else begin
                        rx_n_q <= rx_n_q + NW'(1);
                     end
                  end else begin
                     rx_s_q <= rx_s_q + SW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (rx_s_q == S_LAST) begin
                     rx_s_q       <= '0;
                     rx_par_err_q <= rx_s ^ (^rx_b_q) ^ rx_par_odd_q;
                     rx_state_q   <= ST_STOP;
                  end else begin
                     rx_s_q <= rx_s_q + SW'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (rx_s_q == S_LAST) begin
                     rx_s_q <= '0;
                     if (!rx_stop2_q) rx_frm_err_q <= ~rx_s;
                     if (rx_two_q && !rx_stop2_q) begin
                        rx_stop2_q <= 1'b1;
                     end else begin
                        rx_done_q  <= 1'b1;
                        rx_state_q <= ST_IDLE;
                     end
                  end else begin
                     rx_s_q <= rx_s_q + SW'(1);
                  end
               end
            end
            default: rx_state_q <= ST_IDLE;
         endcase
      end
   end

   logic            rx_full, overrun_q;
   logic [DBIT+1:0] rx_head;

   uart_cfg_fifo #(.W(DBIT + 2), .AW(RX_AW)) u_rx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (rx_done_q),
      .pop_i   (rd_uart),
      .wdata_i ({rx_frm_err_q, rx_par_err_q, rx_b_q}),
      .rdata_o (rx_head),
      .empty_o (rx_empty),
      .full_o  (rx_full)
   );

   assign r_data     = rx_head[DBIT-1:0];
   assign r_par_err  = rx_head[DBIT];
   assign r_frm_err  = rx_head[DBIT+1];
   assign rx_overrun = overrun_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    overrun_q <= 1'b0;
      else if (rx_done_q && rx_full && !rd_uart)  overrun_q <= 1'b1;
      else if (clr_overrun)                       overrun_q <= 1'b0;
   end

   state_t          tx_state_q;
   logic [SW-1:0]   tx_s_q;
   logic [NW-1:0]   tx_n_q;
   logic [DBIT-1:0] tx_b_q;
   logic            tx_par_bit_q, tx_par_en_q, tx_two_q, tx_stop2_q, tx_q;
   logic            tx_empty, tx_pop, tx_stop_end;
   logic [DBIT-1:0] tx_head;

   uart_cfg_fifo #(.W(DBIT), .AW(TX_AW)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (wr_uart),
      .pop_i   (tx_pop),
      .wdata_i (w_data),
      .rdata_o (tx_head),
      .empty_o (tx_empty),
      .full_o  (tx_full)
   );

   // Popping on the final stop tick starts the next frame with no idle gap
   assign tx_stop_end = (tx_state_q == ST_STOP) && tick && (tx_s_q == S_LAST) &&
                        (tx_stop2_q || !tx_two_q);
   assign tx_pop      = !tx_empty && ((tx_state_q == ST_IDLE) || tx_stop_end);
   assign tx          = tx_q;
   assign tx_busy     = (tx_state_q != ST_IDLE) || !tx_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q   <= ST_IDLE;
         tx_s_q       <= '0;
         tx_n_q       <= '0;
         tx_b_q       <= '0;
         tx_par_bit_q <= 1'b0;
         tx_par_en_q  <= 1'b0;
         tx_two_q     <= 1'b0;
         tx_stop2_q   <= 1'b0;
         tx_q         <= 1'b1;
      end else if (tx_pop) begin
         tx_state_q   <= ST_START;
         tx_s_q       <= '0;
         tx_b_q       <= tx_head;
         tx_par_bit_q <= (^tx_head) ^ parity_odd;
         tx_par_en_q  <= parity_en;
         tx_two_q     <= two_stop;
         tx_stop2_q   <= 1'b0;
         tx_q         <= 1'b0;
      end else begin
         case (tx_state_q)
            ST_IDLE: tx_q <= 1'b1;
            ST_START: begin
               if (tick) begin
                  if (tx_s_q == S_LAST) begin
                     tx_s_q     <= '0;
                     tx_n_q     <= '0;
                     tx_q       <= tx_b_q[0];
                     tx_state_q <= ST_DATA;
                  end else begin
                     tx_s_q <= tx_s_q + SW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (tx_s_q == S_LAST) begin
                     tx_s_q <= '0;
                     tx_b_q <= tx_b_q >> 1;
                     if (tx_n_q == N_LAST) begin
                        tx_state_q <= tx_par_en_q ? ST_PARITY : ST_STOP;
                        tx_q       <= tx_par_en_q ? tx_par_bit_q : 1'b1;
                     end else begin
                        tx_n_q <= tx_n_q + NW'(1);
                        tx_q   <= tx_b_q[1];
                     end
                  end else begin
                     tx_s_q <= tx_s_q + SW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (tick) begin
                  if (tx_s_q == S_LAST) begin
                     tx_s_q     <= '0;
                     tx_q       <= 1'b1;
                     tx_state_q <= ST_STOP;
                  end else begin
                     tx_s_q <= tx_s_q + SW'(1);
                  end
               end
            end
            ST_STOP: begin
               if (tick) begin
                  if (tx_s_q == S_LAST) begin
                     tx_s_q <= '0;
                     if (tx_two_q && !tx_stop2_q) tx_stop2_q <= 1'b1;
                     else                         tx_state_q <= ST_IDLE;
                  end else begin
                     tx_s_q <= tx_s_q + SW'(1);
                  end
               end
            end
            default: begin
               tx_state_q <= ST_IDLE;
               tx_q       <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_cfg_core.sv
// Self-checking bench for uart_cfg_core: serial RX frames, parity/framing tags, overrun,
// 8E2 loopback timing and mid-frame reset, with a scoreboard of expected RX FIFO entries.
module tb_uart_cfg_core;
   localparam int DBIT     = 8;
   localparam int SB_TICK  = 16;
   localparam int RX_AW    = 2;
   localparam int TX_AW    = 2;
   localparam int BITS     = 11;
   localparam int FV       = 3;
   localparam int BIT_CLKS = SB_TICK * (FV + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic [BITS-1:0] FINAL_VALUE;
   logic            parity_en, parity_odd, two_stop;
   logic            rx, rd_uart, clr_overrun, wr_uart;
   logic [DBIT-1:0] w_data, r_data;
   logic            r_par_err, r_frm_err, rx_empty, rx_overrun, tx_full, tx, tx_busy;
   logic            rx_drv, loop_en;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DBIT+1:0] exp_q[$];

   assign rx = loop_en ? tx : rx_drv;

   always #5 clk = ~clk;

   uart_cfg_core #(
      .DBIT(DBIT), .SB_TICK(SB_TICK), .RX_AW(RX_AW), .TX_AW(TX_AW), .BITS(BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .FINAL_VALUE (FINAL_VALUE),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .two_stop    (two_stop),
      .rx          (rx),
      .rd_uart     (rd_uart),
      .r_data      (r_data),
      .r_par_err   (r_par_err),
      .r_frm_err   (r_frm_err),
      .rx_empty    (rx_empty),
      .rx_overrun  (rx_overrun),
      .clr_overrun (clr_overrun),
      .wr_uart     (wr_uart),
      .w_data      (w_data),
      .tx_full     (tx_full),
      .tx          (tx),
      .tx_busy     (tx_busy)
   );

   task automatic drive_bit(input logic v);
      rx_drv = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rx_drv = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   // Drives one frame on rx using the current mode inputs; queues the expected FIFO entry if kept.
   task automatic send_frame(input logic [DBIT-1:0] d, input logic pbit, input logic stopv,
                             input logic keep);
      logic exp_par;
      exp_par = parity_en ? (pbit != ((^d) ^ parity_odd)) : 1'b0;
      if (keep) exp_q.push_back({~stopv, exp_par, d});
      drive_bit(1'b0);
      for (int i = 0; i < DBIT; i++) drive_bit(d[i]);
      if (parity_en) drive_bit(pbit);
      drive_bit(stopv);
      if (two_stop) drive_bit(1'b1);
      rx_drv = 1'b1;
   endtask

   // Scoreboard drain: waits for the FIFO head, compares it with the oldest expectation, pops it.
   task automatic rx_pop_compare(input string name);
      logic [DBIT+1:0] e;
      int waited;
      waited = 0;
      while (rx_empty && waited < 40 * BIT_CLKS) begin
         @(negedge clk);
         waited++;
      end
      n_tests++;
      if (rx_empty) begin
         n_fail++;
         $display("FAIL %s_avail: rx_empty=1 after %0d cycles, required a received byte", name, waited);
         return;
      end
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s_extra: got byte %02h, required no byte", name, r_data);
      end else begin
         e = exp_q.pop_front();
         n_tests += 3;
         if (r_data !== e[DBIT-1:0]) begin
            n_fail++;
            $display("FAIL %s_data: got %02h, required %02h", name, r_data, e[DBIT-1:0]);
         end
         if (r_par_err !== e[DBIT]) begin
            n_fail++;
            $display("FAIL %s_par: got %b, required %b", name, r_par_err, e[DBIT]);
         end
         if (r_frm_err !== e[DBIT+1]) begin
            n_fail++;
            $display("FAIL %s_frm: got %b, required %b", name, r_frm_err, e[DBIT+1]);
         end
      end
      $display("[TB] %s: rx byte %02h par_err=%0b frm_err=%0b", name, r_data, r_par_err, r_frm_err);
      rd_uart = 1'b1;
      @(negedge clk);
      rd_uart = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_tests += 8;
      if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
      if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_busy: got %b, required 0", tx_busy); end
      if (rx_empty !== 1'b1)   begin n_fail++; $display("FAIL reset_rx_empty: got %b, required 1", rx_empty); end
      if (tx_full !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_full: got %b, required 0", tx_full); end
      if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, required 0", rx_overrun); end
      if (r_data !== '0)       begin n_fail++; $display("FAIL reset_r_data: got %02h, required 00", r_data); end
      if (r_par_err !== 1'b0)  begin n_fail++; $display("FAIL reset_par: got %b, required 0", r_par_err); end
      if (r_frm_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frm: got %b, required 0", r_frm_err); end
      $display("[TB] reset: tx=%b tx_busy=%b rx_empty=%b", tx, tx_busy, rx_empty);
      rst = 1'b0;
      idle_bits(1);
   endtask

   task automatic test_8n1();
      parity_en = 1'b0; two_stop = 1'b0;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      rx_pop_compare("8n1_a5");
      n_tests++;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL 8n1_empty_after_read: got %b, required 1", rx_empty); end
      idle_bits(1);
   endtask

   task automatic test_parity();
      parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
      send_frame(8'h07, 1'b0, 1'b1, 1'b1);
      idle_bits(1);
      rx_pop_compare("even_bad_par");
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      idle_bits(1);
      rx_pop_compare("even_good_par");
      parity_odd = 1'b1;
      send_frame(8'h07, 1'b0, 1'b1, 1'b1);
      idle_bits(1);
      rx_pop_compare("odd_good_par");
      parity_en = 1'b0; parity_odd = 1'b0;
   endtask

   task automatic test_framing();
      parity_en = 1'b0; two_stop = 1'b0;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
      idle_bits(3);
      rx_pop_compare("frm_err_3c");
      n_tests++;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL frm_no_spurious: rx_empty got %b, required 1", rx_empty); end
      rx_drv = 1'b0;
      repeat (2 * (FV + 1)) @(negedge clk);
      idle_bits(12);
      n_tests++;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_rejected: rx_empty got %b, required 1", rx_empty); end
      $display("[TB] glitch: rx_empty=%b", rx_empty);
   endtask

   task automatic test_overrun();
      parity_en = 1'b0; two_stop = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(DBIT'(i), 1'b0, 1'b1, (i <= 4));
      idle_bits(2);
      n_tests++;
      if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b, required 1", rx_overrun); end
      for (int i = 0; i < 4; i++) rx_pop_compare("overrun_fifo");
      n_tests += 2;
      if (rx_empty !== 1'b1)   begin n_fail++; $display("FAIL overrun_drained: rx_empty got %b, required 1", rx_empty); end
      if (rx_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b, required 1", rx_overrun); end
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      n_tests++;
      if (rx_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b, required 0", rx_overrun); end
      $display("[TB] overrun: cleared, rx_overrun=%b", rx_overrun);
   endtask

   task automatic test_loopback();
      logic [DBIT-1:0] lb [3];
      int t_fall, t_end;
      lb[0] = 8'h55; lb[1] = 8'hFF; lb[2] = 8'h00;
      parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
      loop_en = 1'b1;
      t_fall = -1; t_end = -1;
      for (int t = 0; t < 4000 && t_end < 0; t++) begin
         if (t < 3) begin
            wr_uart = 1'b1;
            w_data  = lb[t];
            exp_q.push_back({2'b00, lb[t]});
         end else begin
            wr_uart = 1'b0;
         end
         @(negedge clk);
         if (t_fall < 0 && tx === 1'b0) t_fall = t;
         if (t_fall >= 0 && tx_busy === 1'b0) t_end = t;
      end
      wr_uart = 1'b0;
      n_tests += 2;
      if (t_end < 0 || t_fall < 0) begin
         n_fail++;
         $display("FAIL loop_len: tx_busy never dropped (fall=%0d), required 3 frames", t_fall);
      end else if ((t_end - t_fall) < 3 * 12 * BIT_CLKS - 3 || (t_end - t_fall) > 3 * 12 * BIT_CLKS) begin
         n_fail++;
         $display("FAIL loop_len: got %0d cycles, required %0d..%0d", t_end - t_fall,
                  3 * 12 * BIT_CLKS - 3, 3 * 12 * BIT_CLKS);
      end
      if (tx !== 1'b1) begin n_fail++; $display("FAIL loop_tx_idle: got %b, required 1", tx); end
      $display("[TB] loopback: 3 frames took %0d cycles", t_end - t_fall);
      for (int i = 0; i < 3; i++) rx_pop_compare("loop_8e2");
      loop_en = 1'b0;
      parity_en = 1'b0; two_stop = 1'b0;
      idle_bits(1);
   endtask

   task automatic test_reset_mid();
      parity_en = 1'b0; two_stop = 1'b0;
      w_data = 8'h00; wr_uart = 1'b1;
      @(negedge clk);
      w_data = 8'h81;
      @(negedge clk);
      wr_uart = 1'b0;
      rx_drv = 1'b0;
      repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
      n_tests++;
      if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, required 1", tx_busy); end
      rst = 1'b1;
      @(negedge clk);
      n_tests += 3;
      if (tx !== 1'b1)       begin n_fail++; $display("FAIL midrst_tx: got %b, required 1", tx); end
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_rx_empty: got %b, required 1", rx_empty); end
      if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_tx_fifo: tx_busy got %b, required 0", tx_busy); end
      $display("[TB] mid-frame reset: tx=%b rx_empty=%b tx_busy=%b", tx, rx_empty, tx_busy);
      rx_drv = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
      send_frame(8'h96, 1'b0, 1'b1, 1'b1);
      idle_bits(1);
      rx_pop_compare("after_reset_96");
      n_tests += 2;
      if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL after_reset_empty: got %b, required 1", rx_empty); end
      if (tx_busy !== 1'b0)  begin n_fail++; $display("FAIL after_reset_tx_idle: got %b, required 0", tx_busy); end
   endtask

   initial begin
      rst = 1'b1;
      FINAL_VALUE = BITS'(FV);
      parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
      rx_drv = 1'b1; loop_en = 1'b0;
      rd_uart = 1'b0; clr_overrun = 1'b0; wr_uart = 1'b0; w_data = '0;
      test_reset();
      test_8n1();
      test_parity();
      test_framing();
      test_overrun();
      test_loopback();
      test_reset_mid();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d expected bytes never received, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end
endmodule
